// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Arbiter sequencing: pick a producer, launch, wait for the transmitter
  // to go busy, then wait for the frame to finish.
  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int DEF_MAX_BURST      = 16;
  localparam int DEF_LAUNCH_TIMEOUT = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin one-hot picker: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports:
//   req       request vector
//   ptr       index where the search starts (must be < NUM_REQ)
//   pick      one-hot winner (all zero when nothing requests)
//   pick_id   encoded winner index
//   any_valid at least one request is set
module rr_priority_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      pick_id,
  output logic               any_valid
);

  always_comb begin
    int idx;
    pick      = '0;
    pick_id   = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // ptr + off never exceeds 2*NUM_REQ-2, so one subtraction wraps it.
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        pick[idx] = 1'b1;
        pick_id   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers (round robin + lock).
// Latency: req_ready same cycle as grant, tx_start one cycle later.
// Backpressure: req_ready only in ARB with tx_busy low; producers hold until ready.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req_valid/data/lock   per-requester byte offer; data packed 8 bits each
//   req_ready             one-hot accept, combinational in the grant cycle
//   tx_start, tx_data     launch pulse and held byte to the transmitter
//   tx_busy               transmitter busy flag
//   grant_id/active       current owner and byte-in-flight flag
//   err_timeout           pulse when tx_busy never rose after a launch
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int MAX_BURST      = DEF_MAX_BURST,
  parameter  int LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 grant_active,
  output logic                 err_timeout
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        lock_id;
  logic                 lock_vld;
  logic [BW-1:0]        burst_cnt;
  logic [TW-1:0]        to_cnt;
  logic [NUM_REQ-1:0]   pick;
  logic [IW-1:0]        pick_id;
  logic                 pick_any;
  logic                 owner_hit;
  logic [IW-1:0]        win_id;
  logic                 capture;
  logic                 timeout_hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .pick      (pick),
    .pick_id   (pick_id),
    .any_valid (pick_any)
  );

  // A valid lock owner overrides the round-robin pick.
  assign owner_hit   = lock_vld && req_valid[lock_id];
  assign win_id      = owner_hit ? lock_id : pick_id;
  assign capture     = (state == ARB) && !tx_busy && (owner_hit || pick_any);
  assign timeout_hit = (state == WAIT_BUSY) && !tx_busy &&
                       (int'(to_cnt) == LAUNCH_TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    tx_start  = 1'b0;
    case (state)
      ARB: begin
        if (capture) begin
          state_nxt = LAUNCH;
          req_ready = owner_hit ? (NUM_REQ'(1) << lock_id) : pick;
        end
      end
      LAUNCH: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)          state_nxt = WAIT_DONE;
        else if (timeout_hit) state_nxt = ARB;
      end
      WAIT_DONE: begin
        // Frame length follows the baud rate, so no watchdog here.
        if (!tx_busy) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
    // State sits in ARB during reset; keep the combinational accept quiet
    // so no producer pops a byte that will never be sent.
    if (!reset_n) req_ready = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      err_timeout  <= 1'b0;
      rr_ptr       <= '0;
      lock_vld     <= 1'b0;
      lock_id      <= '0;
      burst_cnt    <= '0;
      to_cnt       <= '0;
    end else begin
      err_timeout <= 1'b0;

      if (capture) begin
        tx_data      <= req_data[win_id*8 +: 8];
        grant_id     <= win_id;
        grant_active <= 1'b1;
        // Pointer moves past every winner, including a locked owner.
        rr_ptr       <= (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
        if (req_lock[win_id] && (int'(burst_cnt) + 1 < MAX_BURST)) begin
          lock_vld  <= 1'b1;
          lock_id   <= win_id;
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          lock_vld  <= 1'b0;
          burst_cnt <= '0;
        end
      end else if (state == ARB && lock_vld && !req_valid[lock_id]) begin
        // Owner went idle: hand arbitration back to round robin.
        lock_vld  <= 1'b0;
        burst_cnt <= '0;
      end

      if (state == LAUNCH)                  to_cnt <= '0;
      else if (state == WAIT_BUSY && !tx_busy) to_cnt <= to_cnt + 1'b1;

      if (timeout_hit) begin
        err_timeout  <= 1'b1;
        grant_active <= 1'b0;
        lock_vld     <= 1'b0;
        burst_cnt    <= '0;
      end

      if (state == WAIT_DONE && !tx_busy) grant_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter against a cycle-numbered reference.
// Latency: n/a.
// Backpressure: producers hold each byte until its req_ready.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int LT = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_lock;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           grant_active;
  logic           err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .MAX_BURST      (MB),
    .LAUNCH_TIMEOUT (LT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_lock     (req_lock),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .err_timeout  (err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Producers: one byte queue per requester.
  logic [7:0] q_dat [N][$];
  logic       q_lck [N][$];

  // Transmitter model: 0 normal, 1 never busy, 2 random (sometimes dead).
  int tx_mode    = 0;
  bit force_busy = 0;
  int busy_left  = 0;
  int fmin = 1, fmax = 6;

  // Reference: free when no byte is in flight; timing tracked by cycle number.
  int         cyc = 0;
  bit         m_fly;
  int         m_cap, m_busy_at, m_err_at;
  int         m_rr, m_own, m_burst;
  logic [7:0] m_dat;
  int         m_gid;
  int         glog[$];
  int         n_starts = 0, n_errs = 0;
  logic [7:0] last_start_dat;

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (q_dat[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_fly = 0; m_rr = 0; m_own = -1; m_burst = 0;
    m_dat = 8'h00; m_gid = 0; m_err_at = -1; m_busy_at = -1; m_cap = -100;
  endtask

  task automatic tick();
    logic [N-1:0] exp_rdy;
    int           win;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = q_dat[i].size() > 0;
      req_data[i*8 +: 8] = req_valid[i] ? q_dat[i][0] : 8'h00;
      req_lock[i]        = req_valid[i] ? q_lck[i][0] : 1'b0;
    end
    tx_busy = force_busy || (busy_left > 0);
    @(negedge clk);

    check_eq("grant_active", 32'(grant_active), 32'(m_fly));
    check_eq("err_timeout", 32'(err_timeout), 32'(cyc == m_err_at));
    check_eq("tx_data", 32'(tx_data), 32'(m_dat));
    check_eq("grant_id", 32'(grant_id), 32'(m_gid));

    exp_rdy = '0;
    win     = -1;
    if (!m_fly) begin
      check_eq("tx_start_idle", 32'(tx_start), 32'd0);
      if (m_own >= 0 && !req_valid[m_own]) begin m_own = -1; m_burst = 0; end
      if (!tx_busy) begin
        if (m_own >= 0) win = m_own;
        else for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (win < 0 && req_valid[j]) win = j;
        end
      end
      if (win >= 0) begin
        exp_rdy[win] = 1'b1;
        m_fly = 1; m_cap = cyc; m_busy_at = -1;
        m_dat = req_data[win*8 +: 8];
        m_gid = win;
        glog.push_back(win);
        if (req_lock[win] && (m_burst + 1 < MB)) begin m_own = win; m_burst++; end
        else begin m_own = -1; m_burst = 0; end
        m_rr = (win + 1) % N;
      end
    end else begin
      check_eq("tx_start", 32'(tx_start), 32'(cyc == m_cap + 1));
      if (cyc >= m_cap + 2) begin
        if (m_busy_at < 0) begin
          if (tx_busy) m_busy_at = cyc;
          else if (cyc - (m_cap + 2) == LT - 1) begin
            m_fly = 0; m_err_at = cyc + 1; m_own = -1; m_burst = 0;
          end
        end else if (cyc > m_busy_at && !tx_busy) begin
          m_fly = 0;
        end
      end
    end
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));

    if (tx_start) begin n_starts++; last_start_dat = tx_data; end
    if (err_timeout) n_errs++;
    if (busy_left > 0) busy_left--;
    if (tx_start) begin
      if (tx_mode == 0 || (tx_mode == 2 && $urandom_range(5, 0) != 0))
        busy_left = $urandom_range(fmax, fmin);
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i] && q_dat[i].size() > 0) begin
        void'(q_dat[i].pop_front());
        void'(q_lck[i].pop_front());
      end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pending() || m_fly) && n < budget) begin tick(); n++; end
    if (pending() || m_fly) check_eq("drain_budget", 32'd1, 32'd0);
    repeat (2) tick();
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    q_dat[r].push_back(d);
    q_lck[r].push_back(l);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_grant_active", 32'(grant_active), 32'd0);
    check_eq("rst_err_timeout", 32'(err_timeout), 32'd0);
    req_valid = '0; req_data = '0; req_lock = '0; tx_busy = 1'b0;
    busy_left = 0; force_busy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int s0, e0, n0;
    int exp_seq[$];
    reset_n = 1'b0; req_valid = '0; req_data = '0; req_lock = '0; tx_busy = 1'b0;
    do_reset();

    // Single byte from requester 2.
    glog.delete(); s0 = n_starts;
    push(2, 8'hA5, 1'b0);
    drain(200);
    check_eq("single_count", 32'(glog.size()), 32'd1);
    if (glog.size() > 0) check_eq("single_id", 32'(glog[0]), 32'd2);
    check_eq("single_starts", 32'(n_starts - s0), 32'd1);
    check_eq("single_data", 32'(last_start_dat), 32'hA5);

    // Round robin after a last grant of 0.
    push(0, 8'h11, 1'b0);
    drain(200);
    glog.delete(); s0 = n_starts;
    for (int r = 0; r < N; r++) begin
      push(r, 8'(8'h20 + r), 1'b0);
      push(r, 8'(8'h30 + r), 1'b0);
    end
    drain(500);
    exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0};
    check_eq("rr_count", 32'(glog.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < glog.size(); i++)
      check_eq("rr_order", 32'(glog[i]), 32'(exp_seq[i]));
    check_eq("rr_starts", 32'(n_starts - s0), 32'd8);

    // Lock burst: requester 1 locked for 20 bytes, requester 3 waiting.
    glog.delete();
    for (int i = 0; i < 20; i++) push(1, 8'($urandom), 1'b1);
    push(3, 8'h3C, 1'b0);
    drain(1500);
    exp_seq.delete();
    for (int i = 0; i < MB; i++) exp_seq.push_back(1);
    exp_seq.push_back(3);
    for (int i = 0; i < 20 - MB; i++) exp_seq.push_back(1);
    check_eq("lock_count", 32'(glog.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < glog.size(); i++)
      check_eq("lock_order", 32'(glog[i]), 32'(exp_seq[i]));

    // Watchdog: transmitter never goes busy.
    tx_mode = 1; glog.delete(); e0 = n_errs;
    push(0, 8'h5A, 1'b1);
    push(2, 8'hC3, 1'b0);
    drain(200);
    check_eq("wd_errs", 32'(n_errs - e0), 32'd2);
    check_eq("wd_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check_eq("wd_first", 32'(glog[0]), 32'd2);
      check_eq("wd_second", 32'(glog[1]), 32'd0);
    end
    tx_mode = 0;

    // Busy in ARB blocks all grants.
    force_busy = 1; glog.delete(); s0 = n_starts;
    push(1, 8'h77, 1'b0);
    repeat (10) tick();
    check_eq("busy_no_grant", 32'(glog.size()), 32'd0);
    check_eq("busy_no_start", 32'(n_starts - s0), 32'd0);
    force_busy = 0;
    drain(200);
    check_eq("busy_release", 32'(glog.size()), 32'd1);

    // Random traffic with random locks and occasionally dead frames.
    tx_mode = 2;
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 12; i++)
        push($urandom_range(N - 1, 0), 8'($urandom), 1'($urandom_range(1, 0)));
      drain(3000);
    end
    tx_mode = 0;

    // Reset in the middle of a long frame.
    fmin = 20; fmax = 20;
    push(3, 8'hE7, 1'b1);
    n0 = 0;
    while (!(m_fly && m_busy_at >= 0 && cyc > m_busy_at + 2) && n0 < 50) begin tick(); n0++; end
    check_eq("mid_frame_reached", 32'(n0 < 50), 32'd1);
    #2;
    do_reset();
    fmin = 1; fmax = 6;
    glog.delete(); s0 = n_starts;
    repeat (3) tick();
    check_eq("post_rst_no_start", 32'(n_starts - s0), 32'd0);
    for (int r = 0; r < N; r++) push(r, 8'(8'h40 + r), 1'b0);
    drain(500);
    if (glog.size() > 0) check_eq("post_rst_first", 32'(glog[0]), 32'd0);
    else check_eq("post_rst_first", 32'd1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
